// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART serial transmitter among N_REQ byte-stream requesters.
// Ownership is handed out round-robin and is held for a whole packet (up to
// req_last_i) or for at most MAX_BURST bytes, whichever comes first. The
// owner's bytes are forwarded as tx_data_o together with a one-cycle
// data_write_en_o strobe, paced by the transmitter's tx_ready_i handshake.
//
// Ports
//   clk_i            system clock
//   rst_i            synchronous active-high reset
//   req_valid_i      per-requester byte valid
//   req_data_i       per-requester byte, requester k on bits [8k+7:8k]
//   req_last_i       per-requester "last byte of packet" flag
//   req_ready_o      combinational byte accept, one-hot or zero
//   tx_ready_i       transmitter idle and able to take a byte
//   tx_data_o        byte to the transmitter (held until the next accept)
//   data_write_en_o  one-cycle write strobe to the transmitter
//   grant_vld_o      a requester currently owns the transmitter
//   grant_id_o       index of the owner, meaningful while grant_vld_o=1
//   busy_o           arbiter is not idle
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 16,
   parameter int ID_W      = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N_REQ-1:0]     req_valid_i,
   input  logic [8*N_REQ-1:0]   req_data_i,
   input  logic [N_REQ-1:0]     req_last_i,
   output logic [N_REQ-1:0]     req_ready_o,
   input  logic                 tx_ready_i,
   output logic [7:0]           tx_data_o,
   output logic                 data_write_en_o,
   output logic                 grant_vld_o,
   output logic [ID_W-1:0]      grant_id_o,
   output logic                 busy_o
);

   // With MAX_BURST=0 the counter is kept at one bit and simply saturates.
   localparam int BC_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
   localparam logic [BC_W-1:0] BC_MAX = (MAX_BURST > 0) ? BC_W'(MAX_BURST) : {BC_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_ACK
   } state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
   logic              last_q, last_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              wr_en_q, wr_en_d;
   logic              grant_vld_q, grant_vld_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;

   logic              pick_found;
   logic [ID_W-1:0]   pick_idx;
   logic              own_valid;
   logic              own_last;
   logic [7:0]        own_data;
   logic              accept;
   logic              burst_limit;

   // (a + step) mod N_REQ, for step in 0..N_REQ-1.
   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] a, input int step);
      int s;
      s = int'(a) + step;
      if (s >= N_REQ) s = s - N_REQ;
      return ID_W'(s);
   endfunction

   // Round-robin pick: first valid requester scanning from rr_ptr upward.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!pick_found && req_valid_i[wrap_inc(rr_ptr_q, i)]) begin
            pick_found = 1'b1;
            pick_idx   = wrap_inc(rr_ptr_q, i);
         end
      end
   end

   assign own_valid = req_valid_i[grant_id_q];
   assign own_last  = req_last_i[grant_id_q];
   assign own_data  = req_data_i[8*grant_id_q +: 8];

   // The strobe cycle is excluded: tx_ready_i has not yet reflected the
   // byte just written, so accepting again would overrun the transmitter.
   assign accept = (state_q == ST_SEND) & tx_ready_i & own_valid & ~wr_en_q;

   assign req_ready_o = accept ? (N_REQ'(1) << grant_id_q) : '0;

   assign burst_limit = (MAX_BURST != 0) && (burst_cnt_q == BC_MAX);

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      last_d      = last_q;
      tx_data_d   = tx_data_q;
      wr_en_d     = 1'b0;
      grant_vld_d = grant_vld_q;
      grant_id_d  = grant_id_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               grant_id_d  = pick_idx;
               grant_vld_d = 1'b1;
               burst_cnt_d = '0;
               state_d     = ST_SEND;
            end
         end

         ST_SEND: begin
            // Owner may pause mid-packet; the grant is held meanwhile.
            if (accept) begin
               tx_data_d = own_data;
               wr_en_d   = 1'b1;
               last_d    = own_last;
               if (burst_cnt_q != {BC_W{1'b1}}) burst_cnt_d = burst_cnt_q + 1'b1;
               state_d   = ST_WAIT_ACK;
            end
         end

         ST_WAIT_ACK: begin
            // tx_ready_i falling means the transmitter has taken the byte.
            if (!wr_en_q && !tx_ready_i) begin
               if (last_q || burst_limit) begin
                  grant_vld_d = 1'b0;
                  rr_ptr_d    = wrap_inc(grant_id_q, 1);
                  state_d     = ST_IDLE;
               end else begin
                  state_d = ST_SEND;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         last_q      <= 1'b0;
         tx_data_q   <= '0;
         wr_en_q     <= 1'b0;
         grant_vld_q <= 1'b0;
         grant_id_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         last_q      <= last_d;
         tx_data_q   <= tx_data_d;
         wr_en_q     <= wr_en_d;
         grant_vld_q <= grant_vld_d;
         grant_id_q  <= grant_id_d;
      end
   end

   assign tx_data_o       = tx_data_q;
   assign data_write_en_o = wr_en_q;
   assign grant_vld_o     = grant_vld_q;
   assign grant_id_o      = grant_id_q;
   assign busy_o          = (state_q != ST_IDLE);

endmodule
